sdp_bram_scanner: RTL and testbench
===================================

Name: sdp_bram_scanner

Overview:
- Read-side client for the 1-bit simple dual-port bitmap RAM.
- Walks an inclusive address range through the RAM read port and absorbs the RAM's 1-cycle registered read latency.
- Streams the address of every set bit over a valid/ready interface and counts them.
- Sits between a bitmap RAM and downstream solver logic (flood fill, neighbour scan, answer counting).

Parameters:
ADDR_W, 17, RAM address width; range and output address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse begins a scan; ignored while busy=1
first_addr  input  ADDR_W  first address scanned, sampled with start
last_addr  input  ADDR_W  last address scanned (inclusive), sampled with start
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse when scan fully drained
mem_read_addr  output  ADDR_W  to RAM read_addr
mem_read_val  input  1  from RAM read_val, valid one cycle after address sampled
mem_write_addr  output  ADDR_W  to RAM write_addr (feature only)
mem_write_val  output  1  to RAM write_val (feature only)
mem_write_en  output  1  to RAM write_en (feature only)
out_valid  output  1  out_addr holds a set-bit address
out_ready  input  1  downstream accepts when out_valid&out_ready
out_addr  output  ADDR_W  address of a set bit
set_count  output  ADDR_W+1  set bits emitted this scan

Behaviour:
- Reset: busy, done, out_valid, mem_write_en, mem_write_val = 0; out_addr, mem_read_addr, mem_write_addr, set_count = 0; state IDLE; skid and pending flags cleared. Applies immediately; a scan in progress is abandoned with no done pulse.
- States:
  - IDLE: start → SCAN if first_addr<=last_addr, else → DRAIN. start clears set_count and loads an ADDR_W+1-bit counter with first_addr.
  - SCAN: issues reads; → DRAIN after last_addr is issued.
  - DRAIN: waits for all in-flight data, skid and output to empty, then pulses done and → IDLE.
- Read issue: in SCAN, issue in a cycle iff skid empty and (out_valid=0 or out_ready=1).
  - mem_read_addr = counter; counter increments on issue; a pending flag records that a read is in flight.
  - Non-issue cycles hold mem_read_addr; the returned data is ignored.
- Result capture (cycle after issue):
  - mem_read_val=1 and output register free or being accepted → load out_addr, out_valid=1.
  - Otherwise a set bit goes to a 1-entry skid register.
  - Skid drains into the output register before any new result.
  - Zero bits are discarded.
- No set bit is lost or duplicated; emission order is ascending address.
- Latency: start sampled at edge E0 → first read sampled by RAM at E1 → out_valid high after E2 if first_addr is set.
- Throughput: 1 address/cycle with out_ready held high.
- set_count increments on each out_valid&out_ready handshake. Full range 2^ADDR_W gives a max of 2^ADDR_W, hence width ADDR_W+1.
- Wrap: the counter is ADDR_W+1 bits, so last_addr = 2^ADDR_W-1 terminates without wrapping to 0.
- Empty range (first>last): no reads; done pulses the cycle after start; set_count=0.
- Back-to-back: start in the done cycle is ignored; the next scan can start the cycle after done.

Optional Feature:
- Macro: SDP_BRAM_SCANNER_CLEAR_ON_READ_EN
- Defined: in the result-capture cycle of a set bit, mem_write_en=1, mem_write_addr=captured address, mem_write_val=0, clearing the bit.
  - Each address is read once, so there is no read/write hazard.
  - A bit is cleared even if its emission is later held by backpressure.
- Undefined: mem_write_en, mem_write_val and mem_write_addr constant 0.

Test Plan:
1. Bits 3,7,8 set; range 0..15; out_ready=1 → out_addr 3,7,8 ascending; set_count=3; one done pulse within 20 cycles of start; busy low after done.
2. As test 1, with out_ready low for 10 cycles after first out_valid, then toggling 1/0 → same sequence 3,7,8, no duplicates, out_addr stable while stalled; set_count=3.
3. first_addr=5, last_addr=4 → done exactly one cycle after start; out_valid never high; no reads issued; set_count=0.
4. ADDR_W=17, full range 0..131071, bits 0 and 131071 set → outputs 0 then 131071; no wrap re-read of address 0; set_count=2; done once.
5. rst asserted mid-scan (after first output) → all outputs 0 immediately, no done; a new start then rescans correctly.
6. With SDP_BRAM_SCANNER_CLEAR_ON_READ_EN: scan of test 1 pulses mem_write_en three times (addr 3,7,8, val 0); rescan of same range → no outputs, set_count=0.

Source files
------------

// File: rtl/sdp_bram_scanner.sv
// Scans an inclusive address range of a 1-bit registered-read bitmap RAM and streams set-bit addresses.
// Optional clear-on-read write-back is enabled by defining SDP_BRAM_SCANNER_CLEAR_ON_READ_EN.
module sdp_bram_scanner #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic              mem_read_val,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic              mem_write_val,
   output logic              mem_write_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W:0]   set_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state;
   // One bit wider than an address so a range ending at the top address terminates cleanly.
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W-1:0] last_reg;
   logic [ADDR_W-1:0] cap_addr;
   logic [ADDR_W-1:0] skid_addr;
   logic              pending;
   logic              skid_valid;
   logic              issue;
   logic              hit;
   logic              out_free;
   logic              drained;

   assign out_free      = !out_valid || out_ready;
   // Only issue when the result is guaranteed a home next cycle (output or skid).
   assign issue         = (state == S_SCAN) && !skid_valid && out_free;
   assign hit           = pending && mem_read_val;
   assign drained       = !pending && !skid_valid && !out_valid;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DRAIN) && drained;
   assign mem_read_addr = cnt[ADDR_W-1:0];

`ifdef SDP_BRAM_SCANNER_CLEAR_ON_READ_EN
   assign mem_write_en   = hit;
   assign mem_write_addr = cap_addr;
   assign mem_write_val  = 1'b0;
`else
   assign mem_write_en   = 1'b0;
   assign mem_write_addr = '0;
   assign mem_write_val  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         last_reg   <= '0;
         cap_addr   <= '0;
         skid_addr  <= '0;
         pending    <= 1'b0;
         skid_valid <= 1'b0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         set_count  <= '0;
      end else begin
         if (out_valid && out_ready) begin
            set_count <= set_count + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt       <= {1'b0, first_addr};
                  last_reg  <= last_addr;
                  set_count <= '0;
                  state     <= (first_addr <= last_addr) ? S_SCAN : S_DRAIN;
               end
            end
            S_SCAN: begin
               if (issue && (cnt == {1'b0, last_reg})) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drained) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         pending <= issue;
         if (issue) begin
            cnt      <= cnt + 1'b1;
            cap_addr <= cnt[ADDR_W-1:0];
         end

         // The skid entry is older than any fresh hit, so it always drains first.
         if (out_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_addr   <= skid_addr;
               skid_valid <= hit;
               skid_addr  <= cap_addr;
            end else if (hit) begin
               out_valid <= 1'b1;
               out_addr  <= cap_addr;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (hit) begin
            skid_valid <= 1'b1;
            skid_addr  <= cap_addr;
         end
      end
   end

endmodule

// File: tb/tb_sdp_bram_scanner.sv
// Directed bench for sdp_bram_scanner with a behavioural 1-bit registered-read RAM.
// A 10-bit address width keeps the full-range scan short.
module tb_sdp_bram_scanner;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_read_addr;
   logic          mem_read_val;
   logic [AW-1:0] mem_write_addr;
   logic          mem_write_val;
   logic          mem_write_en;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [AW:0]   set_count;

   bit ram [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   sdp_bram_scanner #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
      .busy(busy), .done(done), .mem_read_addr(mem_read_addr), .mem_read_val(mem_read_val),
      .mem_write_addr(mem_write_addr), .mem_write_val(mem_write_val), .mem_write_en(mem_write_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .set_count(set_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_read_val <= ram[mem_read_addr];
      if (mem_write_en) ram[mem_write_addr] <= mem_write_val;
   end

   typedef struct {
      string              name;
      int                 first;
      int                 last;
      int                 mode;   // 0: ready always high, 1: stall 10 cycles then toggle
      int                 nbits;
      logic [3:0][AW-1:0] bits;
      int                 exp_n;
      logic [3:0][AW-1:0] exp;
   } vec_t;

   function automatic vec_t mk(input string name, input int first, input int last, input int mode,
                               input int nbits, input int b0, input int b1, input int b2, input int b3,
                               input int exp_n, input int e0, input int e1, input int e2, input int e3);
      vec_t v;
      v.name = name; v.first = first; v.last = last; v.mode = mode; v.nbits = nbits;
      v.bits[0] = AW'(b0); v.bits[1] = AW'(b1); v.bits[2] = AW'(b2); v.bits[3] = AW'(b3);
      v.exp_n = exp_n;
      v.exp[0] = AW'(e0); v.exp[1] = AW'(e1); v.exp[2] = AW'(e2); v.exp[3] = AW'(e3);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic load_ram(input vec_t v);
      for (int i = 0; i < DEPTH; i++) ram[i] = 1'b0;
      for (int b = 0; b < v.nbits; b++) ram[v.bits[b]] = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input bit reload);
      int got[$];
      int dones      = 0;
      int done_cyc   = -1;
      int first_valid = -1;
      int writes     = 0;
      int cnt_at_done = -1;
      int vld_seen   = 0;
      logic [AW-1:0] held = '0;
      bit held_v = 1'b0;
      if (reload) load_ram(v);
      @(negedge clk);
      first_addr = AW'(v.first);
      last_addr  = AW'(v.last);
      out_ready  = (v.mode == 0);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({v.name, "_busy_after_start"}, int'(busy), 1);
      for (int cyc = 1; cyc < 2200; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (v.mode == 1)
            out_ready = (first_valid >= 0 && cyc >= first_valid + 10) ? cyc[0] : 1'b0;
         if (held_v) begin
            check({v.name, "_stall_valid"}, int'(out_valid), 1);
            check({v.name, "_stall_addr"}, int'(out_addr), int'(held));
         end
         if (out_valid) begin
            vld_seen++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (out_valid && out_ready) got.push_back(int'(out_addr));
         held_v = out_valid && !out_ready;
         held   = out_addr;
         if (mem_write_en) begin
            check({v.name, "_wr_val"}, int'(mem_write_val), 0);
            if (writes < v.exp_n) check({v.name, "_wr_addr"}, int'(mem_write_addr), int'(v.exp[writes]));
            writes++;
         end
         if (done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               cnt_at_done = int'(set_count);
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check({v.name, "_busy_after_done"}, int'(busy), 0);
         end
         if (done_cyc >= 0 && cyc == done_cyc + 3) break;
      end
      if (done_cyc < 0) begin
         check({v.name, "_done_timeout"}, 0, 1);
      end
      check({v.name, "_done_pulses"}, dones, 1);
      check({v.name, "_set_count"}, cnt_at_done, v.exp_n);
      check({v.name, "_n_out"}, got.size(), v.exp_n);
      for (int i = 0; i < v.exp_n && i < got.size(); i++)
         check({v.name, "_out_addr"}, got[i], int'(v.exp[i]));
      if (v.exp_n == 0) check({v.name, "_valid_seen"}, vld_seen, 0);
      if (v.first > v.last) check({v.name, "_done_latency"}, done_cyc, 1);
      if (v.mode == 0 && v.exp_n > 0)
         check({v.name, "_first_latency"}, first_valid, 3 + int'(v.exp[0]) - v.first);
`ifdef SDP_BRAM_SCANNER_CLEAR_ON_READ_EN
      check({v.name, "_writes"}, writes, v.exp_n);
`else
      check({v.name, "_writes"}, writes, 0);
`endif
      $display("vector %s: range %0d..%0d mode %0d outputs %0d set_count %0d done@%0d",
               v.name, v.first, v.last, v.mode, got.size(), cnt_at_done, done_cyc);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = mk("basic",    0,   15, 0, 3, 3, 7, 8, 0,       3, 3, 7, 8, 0);
      vecs[1] = mk("stall",    0,   15, 1, 3, 3, 7, 8, 0,       3, 3, 7, 8, 0);
      vecs[2] = mk("empty",    5,    4, 0, 2, 4, 5, 0, 0,       0, 0, 0, 0, 0);
      vecs[3] = mk("full",     0, 1023, 0, 2, 0, 1023, 0, 0,    2, 0, 1023, 0, 0);
      vecs[4] = mk("subrange", 4,    8, 0, 4, 3, 7, 8, 9,       2, 7, 8, 0, 0);
      vecs[5] = mk("adjacent", 0,    3, 1, 4, 0, 1, 2, 3,       4, 0, 1, 2, 3);

      rst = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; last_addr = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_set_count", int'(set_count), 0);
      check("reset_read_addr", int'(mem_read_addr), 0);
      check("reset_write_en", int'(mem_write_en), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

      // Asynchronous reset in the middle of a scan, after the first output.
      load_ram(vecs[0]);
      @(negedge clk);
      first_addr = AW'(0); last_addr = AW'(15); out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 30 && !(out_valid && out_ready); c++) @(negedge clk);
      check("midrst_saw_output", int'(out_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_addr", int'(out_addr), 0);
      check("midrst_set_count", int'(set_count), 0);
      check("midrst_read_addr", int'(mem_read_addr), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("midrst_no_done", int'(done), 0);
      end
      rst = 1'b0;
      $display("mid-scan reset applied, rescanning");
      run_vec(vecs[0], 1'b1);

      // A start in the done cycle is ignored.
      @(negedge clk);
      first_addr = AW'(5); last_addr = AW'(4); start = 1'b1;
      @(negedge clk);
      check("b2b_done", int'(done), 1);
      first_addr = AW'(0); last_addr = AW'(15);
      @(negedge clk);
      start = 1'b0;
      check("b2b_ignored_busy", int'(busy), 0);
      check("b2b_ignored_done", int'(done), 0);
      $display("back-to-back start in done cycle ignored");
      run_vec(vecs[0], 1'b1);

`ifdef SDP_BRAM_SCANNER_CLEAR_ON_READ_EN
      run_vec(vecs[0], 1'b1);
      run_vec(mk("rescan_cleared", 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
